ysyx_220053_ifu: RTL

- Instruction fetch stage of the single-issue RV64 core; sits directly upstream of the decode stage and produces the 32-bit instruction word it consumes.
- Holds the PC, issues word fetches to the instruction memory port with a valid/ready request and a valid-only response, and buffers returned words in a small FIFO.
- Presents buffered words to decode over a valid/ready handshake; accepts PC redirects from execute and a halt from the trap path.

---
 rtl/ysyx_220053_ifu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC and issues one word fetch at a time.
// Returned words go into a small FIFO that feeds decode over valid/ready.
// A redirect from execute flushes the FIFO and any in-flight response.
// While halt is high, no new fetch requests are issued.
module ysyx_220053_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc,
    output logic        fetch_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;

    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [63:0] fifo_pc_q   [FIFO_DEPTH];
    logic        fifo_err_q  [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic req_fire;
    logic enq;
    logic deq;
    logic slot_free_now;
    logic slot_free_next;

    // The low two bits of a redirect target are dropped; fetches are word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is dropped in the cycle a redirect arrives, even when it is in WAIT.
    assign enq = (state_q == StWait) && imem_rsp_valid && !redirect_valid;
    assign deq = instr_valid && instr_ready;

    assign instr_valid = (count_q != '0);
    assign instr_o     = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign fetch_fault = instr_valid && fifo_err_q[rd_ptr_q];

    assign slot_free_now  = (count_q < DepthCnt);
    assign slot_free_next = (count_d < DepthCnt);

    // FIFO pointer and occupancy next-state; a redirect empties the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM next-state; redirect takes priority over everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                // With a redirect, the flush guarantees a free slot.
                if (!halt && (redirect_valid || slot_free_now)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (req_fire) begin
                    // An accepted request on a flushed path still owes a response.
                    state_d = redirect_valid ? StDrop : StWait;
                end else if (halt) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    state_d = (!halt && slot_free_next) ? StReq : StIdle;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rsp_valid) begin
                    state_d = (!halt && slot_free_next) ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // PC advances on request acceptance; a redirect overrides the increment.
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (req_fire) begin
            req_pc_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + 64'd4;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; a word, its PC and its fault flag travel together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else if (enq) begin
            fifo_data_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_err_q[wr_ptr_q]  <= imem_rsp_err;
        end
    end

    // Requests are only issued with a free slot, so an enqueue never overflows.
    assert property (@(posedge clk) disable iff (rst) enq |-> (count_q < DepthCnt));
    assert property (@(posedge clk) disable iff (rst) imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

endmodule
